alu_stream: RTL and testbench

//  Parametrised 2-stage pipelined ALU with valid/ready flow control on both sides.

---
 rtl/alu_stream.sv | 145 ++++++++++++++
 tb/tb_alu_stream.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream.sv
// alu_stream: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands and opcode, stage 2 holds the result and its flags.
// A saturating counter tracks completed output handshakes.
module alu_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i_1,
  input  logic [DATA_WIDTH-1:0] data_i_2,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  zero_o,
  output logic                  ovf_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  op_cnt_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W:0]   ONE_X   = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic                 s1_valid;
  logic [W-1:0]         s1_a;
  logic [W-1:0]         s1_b;
  logic [SEL_WIDTH-1:0] s1_sel;

  logic       en1;
  logic       en2;
  logic       bad_op;
  logic [2:0] op;
  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] res;
  logic       res_ovf;
  logic       res_zero;

  // Stage 2 moves when it is empty or being drained; stage 1 loads on an input handshake.
  assign en2     = s1_valid && (!valid_o || ready_i);
  assign ready_o = !rst && (!s1_valid || en2);
  assign en1     = valid_i && ready_o;

  assign op = s1_sel[2:0];

  // Codes above 7 only exist when the opcode field is wider than 3 bits.
  generate
    if (SEL_WIDTH > 3) begin : g_err
      assign bad_op = |s1_sel[SEL_WIDTH-1:3];
    end else begin : g_no_err
      assign bad_op = 1'b0;
    end
  endgenerate

  assign a_x = {1'b0, s1_a};
  assign b_x = {1'b0, s1_b};

  // Result and overflow from the stage-1 operands; B is never read by INC/DEC/NOT.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    if (!bad_op) begin
      case (op)
        3'd0: begin
          res     = a_x + b_x;
          res_ovf = (s1_a[W-1] == s1_b[W-1]) && (res[W-1] != s1_a[W-1]);
        end
        3'd1: begin
          res     = a_x - b_x;
          res_ovf = (s1_a[W-1] != s1_b[W-1]) && (res[W-1] != s1_a[W-1]);
        end
        3'd2: begin
          res     = a_x + ONE_X;
          res_ovf = (s1_a == MAX_POS);
        end
        3'd3: begin
          res     = a_x - ONE_X;
          res_ovf = (s1_a == MIN_NEG);
        end
        3'd4: res = {1'b0, s1_a & s1_b};
        3'd5: res = {1'b0, s1_a | s1_b};
        3'd6: res = {1'b0, s1_a ^ s1_b};
        default: res = {1'b0, ~s1_a};
      endcase
    end
  end

  assign res_zero = (res[W-1:0] == '0);

  // Stage 1 register: operand capture and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else begin
      if (en1) begin
        s1_valid <= 1'b1;
        s1_a     <= data_i_1;
        s1_b     <= data_i_2;
        s1_sel   <= sel_i;
      end else if (en2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 register: result with its flags, held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b0;
      ovf_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      if (en2) begin
        valid_o <= 1'b1;
        data_o  <= res;
        zero_o  <= res_zero;
        ovf_o   <= res_ovf;
        err_o   <= bad_op;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Completed-handshake counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_o <= '0;
    end else if (valid_o && ready_i && (op_cnt_o != '1)) begin
      op_cnt_o <= op_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: random and directed stimulus against a queue-based reference model.
module tb_alu_stream;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_i_1 = '0;
  logic [DW-1:0] data_i_2 = '0;
  logic [SW-1:0] sel_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW:0]   data_o;
  logic          zero_o;
  logic          ovf_o;
  logic          err_o;
  logic [CW-1:0] op_cnt_o;

  alu_stream #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .data_i_1(data_i_1), .data_i_2(data_i_2), .sel_i(sel_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .zero_o(zero_o), .ovf_o(ovf_o), .err_o(err_o), .op_cnt_o(op_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       zero;
    logic       ovf;
    logic       err;
    int         e_acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edges    = 0;
  int   n_out    = 0;
  int   n_acc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference result from the opcode rules using plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int sel);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    ua = int'(a);
    sa = int'($signed(a));
    ub = 0;
    sb = 0;
    if (sel == 0 || sel == 1 || (sel >= 4 && sel <= 6)) begin
      ub = int'(b);
      sb = int'($signed(b));
    end
    e.err = 1'b0;
    e.ovf = 1'b0;
    r = 0;
    s = 0;
    case (sel)
      0: begin r = ua + ub; s = sa + sb; end
      1: begin r = ua - ub; s = sa - sb; end
      2: begin r = ua + 1;  s = sa + 1;  end
      3: begin r = ua - 1;  s = sa - 1;  end
      4: r = ua & ub;
      5: r = ua | ub;
      6: r = ua ^ ub;
      7: r = 255 - ua;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    if (r < 0) r = r + 512;
    if (sel <= 3) e.ovf = (s > 127) || (s < -128);
    e.data  = 9'(r);
    e.zero  = ((r % 256) == 0);
    e.e_acc = 0;
    return e;
  endfunction

  // One clock: drive inputs, check at the falling edge, advance the model, move past the rising edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input int s, input logic r);
    logic exp_ready, exp_valid;
    exp_t e;
    valid_i  = v;
    data_i_1 = a;
    data_i_2 = b;
    sel_i    = SW'(s);
    ready_i  = r;
    @(negedge clk);
    exp_ready = (q.size() < 2) || r;
    exp_valid = (q.size() > 0) && (q[0].e_acc + 1 <= edges);
    check("ready_o", 32'(ready_o), 32'(exp_ready));
    check("valid_o", 32'(valid_o), 32'(exp_valid));
    check("op_cnt_o", 32'(op_cnt_o), 32'((n_out > CNT_MAX) ? CNT_MAX : n_out));
    if (exp_valid) begin
      check("data_o", 32'(data_o), 32'(q[0].data));
      check("zero_o", 32'(zero_o), 32'(q[0].zero));
      check("ovf_o",  32'(ovf_o),  32'(q[0].ovf));
      check("err_o",  32'(err_o),  32'(q[0].err));
      if (r) begin
        void'(q.pop_front());
        n_out++;
      end
    end
    if (exp_ready && v) begin
      e = model(a, b, s);
      e.e_acc = edges + 1;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 0, 1'b1);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_op_cnt_o", 32'(op_cnt_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd0);
    q.delete();
    n_out = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    edges++;
    #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    int rs, acc0;

    #2;
    do_reset();

    // directed arithmetic corners
    cycle(1'b1, 8'hFF, 8'h01, 0, 1'b1);
    cycle(1'b1, 8'h00, 8'h01, 1, 1'b1);
    cycle(1'b1, 8'h7F, 8'h01, 0, 1'b1);
    cycle(1'b1, 8'h80, 8'hxx, 3, 1'b1);
    cycle(1'b1, 8'h7F, 8'hxx, 2, 1'b1);
    cycle(1'b1, 8'h80, 8'h01, 1, 1'b1);
    idle(3);

    // reset with beats in flight
    cycle(1'b1, 8'h12, 8'h34, 0, 1'b0);
    cycle(1'b1, 8'h56, 8'h78, 1, 1'b0);
    do_reset();

    // back-to-back opcodes 0..7
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      cycle(1'b1, ra, rb, i, 1'b1);
    end
    idle(3);
    check("b2b_op_cnt", 32'(op_cnt_o), 32'd8);

    // backpressure: exactly two beats enter while the sink stalls
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 8'h03, i % 2, 1'b0);
    check("bp_accepted", 32'(n_acc - acc0), 32'd2);
    idle(4);

    // undefined opcode followed by a defined one
    cycle(1'b1, 8'h55, 8'hAA, 9, 1'b1);
    cycle(1'b1, 8'h55, 8'hAA, 0, 1'b1);
    idle(3);

    // random traffic with random sink stalls
    for (int i = 0; i < 150; i++) begin
      rs = int'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ((rs == 2 || rs == 3 || rs == 7) && ($urandom_range(0, 1) == 1)) rb = 8'hxx;
      cycle($urandom_range(0, 9) < 7, ra, rb, rs, $urandom_range(0, 9) < 6);
    end
    idle(4);
    check("sat_op_cnt", 32'(op_cnt_o), 32'((n_out > CNT_MAX) ? CNT_MAX : n_out));
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
